// File: rtl/mag_sq_if.sv
// Start/acknowledge bus of the squared-magnitude unit: signed I/Q operands in,
// I^2 + Q^2 with state and valid out.
interface mag_sq_if #(
  parameter int DW = 16
);
  logic              enable;
  logic [DW-1:0]     din_i;
  logic [DW-1:0]     din_q;
  logic [2*DW-1:0]   dout;
  logic [3:0]        cstate;
  logic              valid;

  modport master (
    output enable, din_i, din_q,
    input  dout, cstate, valid
  );

  modport slave (
    input  enable, din_i, din_q,
    output dout, cstate, valid
  );
endinterface

// File: rtl/mag_sq.sv
// Iterative I^2 + Q^2: two shift-add squarers run in parallel for DW cycles,
// then the sum is held in HALT until the controller acknowledges it.
module mag_sq #(
  parameter int DW = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  mag_sq_if.slave  bus
);
  localparam int              CW   = $clog2(DW);
  localparam logic [CW-1:0]   LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t            r_state;
  logic [DW-1:0]     r_mul_i;
  logic [DW-1:0]     r_mul_q;
  logic [2*DW-1:0]   r_mcand_i;
  logic [2*DW-1:0]   r_mcand_q;
  logic [2*DW-1:0]   r_acc_i;
  logic [2*DW-1:0]   r_acc_q;
  logic [2*DW-1:0]   r_dout;
  logic [CW-1:0]     r_cnt;
  logic              r_valid;

  logic [DW-1:0]     w_abs_i;
  logic [DW-1:0]     w_abs_q;

  // |-2^(DW-1)| wraps back to 2^(DW-1), which is the correct unsigned magnitude
  always_comb begin
    w_abs_i = bus.din_i[DW-1] ? (~bus.din_i + DW'(1)) : bus.din_i;
    w_abs_q = bus.din_q[DW-1] ? (~bus.din_q + DW'(1)) : bus.din_q;
  end

  assign bus.dout   = r_dout;
  assign bus.valid  = r_valid;
  assign bus.cstate = {2'b00, r_state};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_mul_i   <= '0;
      r_mul_q   <= '0;
      r_mcand_i <= '0;
      r_mcand_q <= '0;
      r_acc_i   <= '0;
      r_acc_q   <= '0;
      r_dout    <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_mul_i   <= w_abs_i;
          r_mul_q   <= w_abs_q;
          r_mcand_i <= {{DW{1'b0}}, w_abs_i};
          r_mcand_q <= {{DW{1'b0}}, w_abs_q};
          r_acc_i   <= '0;
          r_acc_q   <= '0;
          r_cnt     <= '0;
          if (bus.enable) r_state <= COMPUTE;
        end
        COMPUTE: begin
          if (r_mul_i[0]) r_acc_i <= r_acc_i + r_mcand_i;
          if (r_mul_q[0]) r_acc_q <= r_acc_q + r_mcand_q;
          r_mul_i   <= r_mul_i >> 1;
          r_mul_q   <= r_mul_q >> 1;
          r_mcand_i <= r_mcand_i << 1;
          r_mcand_q <= r_mcand_q << 1;
          if (r_cnt == LAST) r_state <= HALT;
          else               r_cnt   <= r_cnt + 1'b1;
        end
        HALT: begin
          // valid is always low on entry, so it marks the first HALT cycle
          if (!r_valid) begin
            r_dout  <= r_acc_i + r_acc_q;
            r_valid <= 1'b1;
          end else if (bus.enable) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
